// File: rtl/relay_switch_sequencer.sv
// Relay coil sequencer: filters the relay-select request, then switches coils
// with break-before-make dead time and a minimum dwell after each make.
module relay_switch_sequencer #(
  parameter int unsigned STABLE_CYCLES = 3,
  parameter int unsigned DEAD_CYCLES   = 4,
  parameter int unsigned DWELL_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] relay_sel,
  output logic [3:0] coil,
  output logic [1:0] active_sel,
  output logic       busy,
  output logic [7:0] switch_count
);

  localparam int unsigned SW     = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TMAX   = (DEAD_CYCLES > DWELL_CYCLES) ? DEAD_CYCLES : DWELL_CYCLES;
  localparam int unsigned TW     = $clog2(TMAX + 1);
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_HOLD,
    ST_BREAK,
    ST_DWELL
  } state_t;

  state_t           state, state_d;
  logic [1:0]       cand, cand_d;
  logic [SW-1:0]    stab_cnt, stab_d;
  logic [1:0]       target, target_d;
  logic [TW-1:0]    tmr, tmr_d;
  logic [1:0]       act_d;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       coil_d;
  logic             busy_d;
  logic             stable;

  assign stable = (stab_cnt == SW'(STABLE_CYCLES));

  // State and output registers; coil/busy are loaded from the next-state decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_OFF;
      cand         <= '0;
      stab_cnt     <= '0;
      target       <= '0;
      tmr          <= '0;
      active_sel   <= '0;
      switch_count <= '0;
      coil         <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      cand         <= cand_d;
      stab_cnt     <= stab_d;
      target       <= target_d;
      tmr          <= tmr_d;
      active_sel   <= act_d;
      switch_count <= cnt_d;
      coil         <= coil_d;
      busy         <= busy_d;
    end
  end

  always_comb begin
    state_d  = state;
    cand_d   = cand;
    stab_d   = stab_cnt;
    target_d = target;
    tmr_d    = tmr;
    act_d    = active_sel;
    cnt_d    = switch_count;

    // Stability filter runs regardless of state
    if (relay_sel != cand) begin
      cand_d = relay_sel;
      stab_d = '0;
    end else if (!stable) begin
      stab_d = stab_cnt + SW'(1);
    end

    case (state)
      ST_OFF: begin
        if (stable) begin
          target_d = cand;
          act_d    = cand;
          tmr_d    = '0;
          state_d  = ST_DWELL;
        end
      end
      ST_HOLD: begin
        if (stable && (cand != active_sel)) begin
          target_d = cand;
          tmr_d    = '0;
          state_d  = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (tmr == TW'(DEAD_CYCLES - 1)) begin
          act_d   = target;
          cnt_d   = (switch_count == '1) ? switch_count : switch_count + CNT_W'(1);
          tmr_d   = '0;
          state_d = ST_DWELL;
        end else begin
          tmr_d = tmr + TW'(1);
        end
      end
      ST_DWELL: begin
        if (tmr == TW'(DWELL_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = ST_HOLD;
        end else begin
          tmr_d = tmr + TW'(1);
        end
      end
      default: state_d = ST_OFF;
    endcase

    // Coil follows the next state, so it only ever holds a single decoded bit
    coil_d = ((state_d == ST_HOLD) || (state_d == ST_DWELL)) ? 4'(4'b0001 << act_d) : 4'b0000;
    busy_d = (state_d == ST_BREAK) || (state_d == ST_DWELL);
  end

endmodule

// File: tb/tb_relay_switch_sequencer.sv
// Scoreboard bench for relay_switch_sequencer: stimulus queues expected output
// snapshots tagged with the edge they must appear after; a monitor compares.
module tb_relay_switch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] relay_sel;
  logic [3:0] coil;
  logic [1:0] active_sel;
  logic       busy;
  logic [7:0] switch_count;

  relay_switch_sequencer #(
    .STABLE_CYCLES(3),
    .DEAD_CYCLES  (4),
    .DWELL_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .relay_sel   (relay_sel),
    .coil        (coil),
    .active_sel  (active_sel),
    .busy        (busy),
    .switch_count(switch_count)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int               edge_n;
    bit               imm;
    logic [3:0]       coil;
    logic [1:0]       act;
    logic             busy;
    logic [7:0]       cnt;
    bit [8*16-1:0]    name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  bit   mon_en = 1'b0;
  bit   done   = 1'b0;
  bit   fin    = 1'b0;
  logic [14:0] prev = '0;

  task automatic push(input int e, input bit imm, input logic [3:0] c, input logic [1:0] a,
                      input logic b, input logic [7:0] n, input bit [8*16-1:0] name);
    exp_t x;
    x.edge_n = e; x.imm = imm; x.coil = c; x.act = a; x.busy = b; x.cnt = n; x.name = name;
    q.push_back(x);
  endtask

  task automatic cmp(input exp_t e);
    checks++;
    if (coil !== e.coil || active_sel !== e.act || busy !== e.busy || switch_count !== e.cnt) begin
      fails++;
      $display("FAIL %0s edge %0d: got coil=%b act=%0d busy=%b cnt=%0d, want coil=%b act=%0d busy=%b cnt=%0d",
               e.name, edge_cnt, coil, active_sel, busy, switch_count, e.coil, e.act, e.busy, e.cnt);
    end
  endtask

  // Monitor: compares at scheduled edges, flags unscheduled changes and multi-hot coils
  initial begin
    exp_t e;
    wait (mon_en);
    forever begin
      @(negedge clk or posedge rst);
      if (clk) begin
        #1;
        if (q.size() > 0 && q[0].imm) begin
          e = q.pop_front();
          cmp(e);
        end
      end else begin
        while (q.size() > 0 && !q[0].imm && q[0].edge_n < edge_cnt) begin
          e = q.pop_front();
          checks++;
          fails++;
          $display("FAIL %0s missed: expected at edge %0d, now %0d", e.name, e.edge_n, edge_cnt);
        end
        if (q.size() > 0 && !q[0].imm && q[0].edge_n == edge_cnt) begin
          e = q.pop_front();
          cmp(e);
        end else if ({coil, active_sel, busy, switch_count} !== prev) begin
          checks++;
          fails++;
          $display("FAIL unexpected_change edge %0d: got coil=%b act=%0d busy=%b cnt=%0d, want no change from %h",
                   edge_cnt, coil, active_sel, busy, switch_count, prev);
        end
        if (!$onehot0(coil)) begin
          checks++;
          fails++;
          $display("FAIL multi_hot edge %0d: got coil=%b, want at most one bit", edge_cnt, coil);
        end
        if (done && !fin) begin
          checks++;
          if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
          end
          fin = 1'b1;
        end
      end
      prev = {coil, active_sel, busy, switch_count};
    end
  end

  task automatic wait_edge(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  // From OFF: make after S+1 edges, dwell ends after S+1+W
  task automatic engage(input logic [1:0] nsel, input logic [7:0] cnt);
    int base;
    logic [3:0] oh;
    base = edge_cnt;
    oh = 4'b0001 << nsel;
    relay_sel = nsel;
    push(base + 5,  1'b0, oh, nsel, 1'b1, cnt, "engage_make");
    push(base + 21, 1'b0, oh, nsel, 1'b0, cnt, "engage_hold");
    wait_edge(base + 23);
  endtask

  // From HOLD: break after S+1, make after S+1+D, hold after S+1+D+W
  task automatic switch_to(input logic [1:0] nsel, input logic [1:0] osel, inout logic [7:0] cnt);
    int base;
    logic [3:0] oh;
    logic [7:0] ncnt;
    base = edge_cnt;
    oh = 4'b0001 << nsel;
    ncnt = (cnt == 8'd255) ? 8'd255 : cnt + 8'd1;
    relay_sel = nsel;
    push(base + 5,  1'b0, 4'b0000, osel, 1'b1, cnt,  "switch_break");
    push(base + 9,  1'b0, oh,      nsel, 1'b1, ncnt, "switch_make");
    push(base + 25, 1'b0, oh,      nsel, 1'b0, ncnt, "switch_hold");
    cnt = ncnt;
    wait_edge(base + 26);
  endtask

  initial begin
    int base;
    logic [7:0] cnt;
    logic [1:0] cur;
    rst = 1'b1;
    relay_sel = 2'd0;
    repeat (3) @(negedge clk);

    // Release with a non-zero request so relay 0 is not engaged by default
    rst = 1'b0;
    push(edge_cnt + 1, 1'b0, 4'b0000, 2'd0, 1'b0, 8'd0, "reset_state");
    mon_en = 1'b1;
    engage(2'd2, 8'd0);

    cnt = 8'd0;
    switch_to(2'd1, 2'd2, cnt);

    // Glitch: 3 for two samples, then back to 1
    base = edge_cnt;
    relay_sel = 2'd3;
    @(negedge clk);
    @(negedge clk);
    relay_sel = 2'd1;
    push(base + 4, 1'b0, 4'b0010, 2'd1, 1'b0, 8'd1, "glitch_a");
    push(base + 9, 1'b0, 4'b0010, 2'd1, 1'b0, 8'd1, "glitch_b");
    wait_edge(base + 10);

    // Retarget attempt while breaking toward 3
    base = edge_cnt;
    relay_sel = 2'd3;
    push(base + 5, 1'b0, 4'b0000, 2'd1, 1'b1, 8'd1, "retgt_break");
    wait_edge(base + 6);
    relay_sel = 2'd0;
    push(base + 9,  1'b0, 4'b1000, 2'd3, 1'b1, 8'd2, "retgt_make3");
    push(base + 25, 1'b0, 4'b1000, 2'd3, 1'b0, 8'd2, "retgt_hold1");
    push(base + 26, 1'b0, 4'b0000, 2'd3, 1'b1, 8'd2, "retgt_break2");
    push(base + 30, 1'b0, 4'b0001, 2'd0, 1'b1, 8'd3, "retgt_make0");
    push(base + 46, 1'b0, 4'b0001, 2'd0, 1'b0, 8'd3, "retgt_hold0");
    wait_edge(base + 48);

    // Reset in the middle of BREAK
    base = edge_cnt;
    relay_sel = 2'd2;
    push(base + 5, 1'b0, 4'b0000, 2'd0, 1'b1, 8'd3, "rbrk_break");
    wait_edge(base + 6);
    push(0, 1'b1, 4'b0000, 2'd0, 1'b0, 8'd0, "rst_mid_break");
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    engage(2'd2, 8'd0);

    // Asynchronous reset while coil=0100
    push(0, 1'b1, 4'b0000, 2'd0, 1'b0, 8'd0, "rst_async");
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    relay_sel = 2'd1;
    rst = 1'b0;
    engage(2'd1, 8'd0);

    // Saturation: 300 alternating switches
    cnt = 8'd0;
    cur = 2'd1;
    for (int i = 0; i < 300; i++) begin
      logic [1:0] nxt;
      nxt = (cur == 2'd1) ? 2'd2 : 2'd1;
      switch_to(nxt, cur, cnt);
      cur = nxt;
    end

    done = 1'b1;
    repeat (4) @(negedge clk);
    if (!fin) begin
      $display("FAIL monitor_stalled: got fin=0, want 1");
      $fatal(1);
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
